seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider that produces one quotient bit per clock, with a registered
// quotient, remainder and done pulse. Define SEQDIV_SIGNED_EN for two's-complement operation.
module seq_divider #(
    parameter int N = 4
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  q_reg, d_reg;
    logic [N:0]    r_reg;
    logic [CW-1:0] cnt;

    logic [N:0]    r_sh, t, r_next;
    logic [N-1:0]  q_next;
    logic          last_step;
    logic [N-1:0]  a_mag, b_mag, q_fix, r_fix;

    // One restoring step. R stays below D, so the shifted R fits in N+1 bits.
    always_comb begin
        r_sh   = {r_reg[N-1:0], q_reg[N-1]};
        t      = r_sh - {1'b0, d_reg};
        r_next = t[N] ? r_sh : t;
        q_next = {q_reg[N-2:0], ~t[N]};
    end

    assign last_step = (cnt == CW'(N - 1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef SEQDIV_SIGNED_EN
    logic q_neg, r_neg;

    // The core divides magnitudes. Signs are restored when the result is written.
    assign a_mag = dividend[N-1] ? -dividend : dividend;
    assign b_mag = divisor[N-1]  ? -divisor  : divisor;
    assign q_fix = q_neg ? -q_next : q_next;
    assign r_fix = r_neg ? -r_next[N-1:0] : r_next[N-1:0];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            q_neg <= dividend[N-1] ^ divisor[N-1];
            r_neg <= dividend[N-1];
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = q_next;
    assign r_fix = r_next[N-1:0];
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q_reg <= a_mag;
                            d_reg <= b_mag;
                            r_reg <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. It applies directed and random divisions and compares
// the results with an arithmetic reference model.
module tb_seq_divider;
    localparam int N = 4;

    logic         CLOCK_50 = 1'b0;
    logic         resetn;
    logic         start;
    logic [N-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [N-1:0] quotient, remainder;

    int vectors = 0;
    int fails   = 0;

    seq_divider #(.N(N)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [N-1:0] rnd();
        logic [31:0] v;
        v = $urandom;
        return v[N-1:0];
    endfunction

    // Reference results come from plain integer division.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic dz);
        int sa, sb, tq, tr;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
`ifdef SEQDIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = int'(a);
            sb = int'(b);
`endif
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[N-1:0];
            r  = tr[N-1:0];
            dz = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] eq, er;
        logic         ez;
        int           lat, cyc;
        model(a, b, eq, er, ez);
        lat = (b == '0) ? 0 : N;
        @(negedge CLOCK_50);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0; dividend = rnd(); divisor = rnd();
        chk("busy_at_accept", 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 4 * N) begin
            @(posedge CLOCK_50); #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(ez));
        chk("busy_at_done", 32'(busy), 32'd1);
        @(posedge CLOCK_50); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("quotient_hold", 32'(quotient), 32'(eq));
    endtask

    initial begin
        logic [N-1:0] cur_a, cur_b, acc_a, acc_b, eq, er;
        logic         ez;
        int           next_accept, done_at, lat;

        resetn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge CLOCK_50);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        resetn = 1'b1;

        run_div(4'd13, 4'd3);
        run_div(4'd7, 4'd0);
        run_div(4'd15, 4'd1);
        run_div(4'd3, 4'd5);
        run_div(4'd9, 4'd2);
        run_div(4'd7, 4'd14);
        run_div(4'd8, 4'd15);

        for (int a = 0; a < (1 << N); a++)
            for (int b = 0; b < (1 << N); b++)
                run_div(a[N-1:0], b[N-1:0]);

        for (int i = 0; i < 30; i++)
            run_div(rnd(), rnd());

        // Start is held high while operands change every cycle. Only the operands present at
        // an idle edge are accepted.
        @(negedge CLOCK_50);
        cur_a = rnd(); cur_b = rnd();
        dividend = cur_a; divisor = cur_b; start = 1'b1;
        next_accept = 0; done_at = -1; acc_a = '0; acc_b = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLOCK_50); #1;
            if (i == next_accept) begin
                acc_a = cur_a; acc_b = cur_b;
                lat = (cur_b == '0) ? 0 : N;
                done_at = i + lat;
                next_accept = i + lat + 2;
            end
            chk("held_done", 32'(done), 32'(i == done_at));
            if (i == done_at) begin
                model(acc_a, acc_b, eq, er, ez);
                chk("held_quotient", 32'(quotient), 32'(eq));
                chk("held_remainder", 32'(remainder), 32'(er));
                chk("held_dz", 32'(div_by_zero), 32'(ez));
            end
            @(negedge CLOCK_50);
            cur_a = rnd();
            cur_b = ($urandom_range(0, 3) == 0) ? '0 : rnd();
            dividend = cur_a; divisor = cur_b;
        end
        start = 1'b0;
        repeat (N + 3) @(negedge CLOCK_50);

        // Reset in the middle of CALC discards the operation.
        run_div(4'd15, 4'd1);
        @(negedge CLOCK_50);
        dividend = 4'd9; divisor = 4'd2; start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dz", 32'(div_by_zero), 32'd0);
        repeat (2) begin
            @(posedge CLOCK_50); #1;
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        run_div(4'd9, 4'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
